mem_port_arbiter: RTL and testbench

//  Shares one single-port byte memory between two requesters.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port byte memory between two requesters,
// with registered command capture, ready handshake and a timeout watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state, state_next;
    logic               winner;
    logic               last_gnt;
    logic               we_r;
    logic [CNT_W-1:0]   cnt;
    logic               accept, pick, finish, expire;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        pick       = 1'b0;
        finish     = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                    // On a tie the requester that did not win last time goes next
                    pick       = (req0 && req1) ? ~last_gnt : req1;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            winner    <= 1'b0;
            last_gnt  <= 1'b1;
            we_r      <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state <= state_next;
            gnt0  <= accept && !pick;
            gnt1  <= accept && pick;
            done0 <= (finish || expire) && !winner;
            done1 <= (finish || expire) && winner;
            err0  <= expire && !winner;
            err1  <= expire && winner;
            if (accept) begin
                winner    <= pick;
                we_r      <= pick ? we1 : we0;
                mem_addr  <= pick ? addr1 : addr0;
                mem_wdata <= pick ? wdata1 : wdata0;
                cnt       <= '0;
            end else if (state == ISSUE) begin
                cnt <= cnt + 1'b1;
            end
            if (finish || expire)
                last_gnt <= winner;
            if (finish && !we_r) begin
                if (winner)
                    rdata1 <= mem_rdata;
                else
                    rdata0 <= mem_rdata;
            end
        end
    end

    assign busy     = (state == ISSUE);
    assign mem_en   = busy;
    assign mem_w_en = busy && we_r;
    assign mem_r_en = busy && !we_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written
// sequences for the timeout and mid-access reset cases.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       busy, mem_en, mem_w_en, mem_r_en;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ready;
    logic [7:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(7), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .mem_en(mem_en), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // flags = {gnt0,gnt1,done0,done1,err0,err1,busy,mem_en,mem_w_en,mem_r_en}
    typedef struct {
        logic       rst, req0, req1, we0, we1;
        logic [6:0] addr0, addr1;
        logic [7:0] wdata0, wdata1;
        logic       rdy;
        logic [7:0] rdin;
        logic [9:0] flags;
        logic [6:0] eaddr;
        logic [7:0] ewdata, erd0, erd1;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [9:0] flags_now();
        return {gnt0, gnt1, done0, done1, err0, err1, busy, mem_en, mem_w_en, mem_r_en};
    endfunction

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_ready = 0; mem_rdata = '0;

        //            rst req0 req1 we0 we1 addr0  addr1  wd0    wd1    rdy rdin   flags          eaddr  ewd    erd0   erd1
        tbl.push_back('{1, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00, 0, 8'h00, 10'b0000000000, 7'h00, 8'h00, 8'h00, 8'h00});
        // single write, ready after two more ISSUE cycles
        tbl.push_back('{0, 1, 0, 1, 0, 7'h05, 7'h00, 8'hA5, 8'h00, 0, 8'h00, 10'b1000001110, 7'h05, 8'hA5, 8'h00, 8'h00});
        tbl.push_back('{0, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00, 0, 8'h00, 10'b0000001110, 7'h05, 8'hA5, 8'h00, 8'h00});
        tbl.push_back('{0, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00, 0, 8'h00, 10'b0000001110, 7'h05, 8'hA5, 8'h00, 8'h00});
        tbl.push_back('{0, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00, 1, 8'h00, 10'b0010000000, 7'h05, 8'hA5, 8'h00, 8'h00});
        // mem_ready while idle is ignored
        tbl.push_back('{0, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00, 1, 8'hEE, 10'b0000000000, 7'h05, 8'hA5, 8'h00, 8'h00});
        tbl.push_back('{0, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00, 1, 8'hEE, 10'b0000000000, 7'h05, 8'hA5, 8'h00, 8'h00});
        // req1 read returns 3C, then req0 read returns 77 without disturbing rdata1
        tbl.push_back('{0, 0, 1, 0, 0, 7'h00, 7'h11, 8'h00, 8'h00, 0, 8'h00, 10'b0100001101, 7'h11, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{0, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00, 1, 8'h3C, 10'b0001000000, 7'h11, 8'h00, 8'h00, 8'h3C});
        tbl.push_back('{0, 1, 0, 0, 0, 7'h22, 7'h00, 8'h00, 8'h00, 0, 8'h00, 10'b1000001101, 7'h22, 8'h00, 8'h00, 8'h3C});
        tbl.push_back('{0, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00, 1, 8'h77, 10'b0010000000, 7'h22, 8'h00, 8'h77, 8'h3C});
        // reset, then both requesters held: grants alternate 0,1,0,1
        tbl.push_back('{1, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00, 0, 8'h00, 10'b0000000000, 7'h00, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{0, 1, 1, 0, 0, 7'h01, 7'h02, 8'h00, 8'h00, 0, 8'h00, 10'b1000001101, 7'h01, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{0, 1, 1, 0, 0, 7'h01, 7'h02, 8'h00, 8'h00, 1, 8'h11, 10'b0010000000, 7'h01, 8'h00, 8'h11, 8'h00});
        tbl.push_back('{0, 1, 1, 0, 0, 7'h01, 7'h02, 8'h00, 8'h00, 0, 8'h00, 10'b0100001101, 7'h02, 8'h00, 8'h11, 8'h00});
        tbl.push_back('{0, 1, 1, 0, 0, 7'h01, 7'h02, 8'h00, 8'h00, 1, 8'h5A, 10'b0001000000, 7'h02, 8'h00, 8'h11, 8'h5A});
        tbl.push_back('{0, 1, 1, 0, 0, 7'h01, 7'h02, 8'h00, 8'h00, 0, 8'h00, 10'b1000001101, 7'h01, 8'h00, 8'h11, 8'h5A});
        tbl.push_back('{0, 1, 1, 0, 0, 7'h01, 7'h02, 8'h00, 8'h00, 1, 8'h6B, 10'b0010000000, 7'h01, 8'h00, 8'h6B, 8'h5A});
        tbl.push_back('{0, 1, 1, 0, 0, 7'h01, 7'h02, 8'h00, 8'h00, 0, 8'h00, 10'b0100001101, 7'h02, 8'h00, 8'h6B, 8'h5A});
        tbl.push_back('{0, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00, 1, 8'hC3, 10'b0001000000, 7'h02, 8'h00, 8'h6B, 8'hC3});

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req0 = tbl[i].req0; req1 = tbl[i].req1;
            we0 = tbl[i].we0; we1 = tbl[i].we1;
            addr0 = tbl[i].addr0; addr1 = tbl[i].addr1;
            wdata0 = tbl[i].wdata0; wdata1 = tbl[i].wdata1;
            mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdin;
            tick();
            check($sformatf("vec%0d", i),
                  64'({flags_now(), mem_addr, mem_wdata, rdata0, rdata1}),
                  64'({tbl[i].flags, tbl[i].eaddr, tbl[i].ewdata, tbl[i].erd0, tbl[i].erd1}));
        end

        // timeout: req0 read with mem_ready held low
        begin
            int  ren_cycles = 0;
            bit  seen_done = 0;
            mem_ready = 0; mem_rdata = 8'hFF;
            req0 = 1; we0 = 0; addr0 = 7'h33;
            tick();
            check("to_gnt", 64'({gnt0, gnt1, mem_r_en, mem_addr}), 64'({1'b1, 1'b0, 1'b1, 7'h33}));
            req0 = 0;
            ren_cycles = 1;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (done0) begin
                    seen_done = 1;
                    break;
                end
                if (mem_r_en) ren_cycles++;
            end
            check("to_seen_done", 64'(seen_done), 64'(1));
            check("to_ren_cycles", 64'(ren_cycles), 64'(15));
            check("to_done_err", 64'({done0, err0, done1, err1}), 64'(4'b1100));
            check("to_rdata0_held", 64'(rdata0), 64'(8'h6B));
            check("to_idle", 64'({busy, mem_en, mem_r_en}), 64'(0));
            tick();
            check("to_pulse_end", 64'({done0, err0}), 64'(0));
        end

        // reset on the second ISSUE cycle of a req1 write
        req1 = 1; we1 = 1; addr1 = 7'h44; wdata1 = 8'h99;
        tick();
        check("rst_gnt1", 64'({gnt1, mem_w_en, mem_addr, mem_wdata}), 64'({1'b1, 1'b1, 7'h44, 8'h99}));
        req1 = 0; we1 = 0;
        tick();
        check("rst_issue2", 64'({gnt1, busy, mem_w_en}), 64'(3'b011));
        rst = 1;
        tick();
        check("rst_clear", 64'({flags_now(), mem_addr, mem_wdata, rdata0, rdata1}), 64'(0));
        rst = 0; req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 7'h0A; addr1 = 7'h0B;
        tick();
        check("rst_tie_req0", 64'({gnt0, gnt1, done1, err1, mem_addr}), 64'({4'b1000, 7'h0A}));
        req0 = 0; req1 = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
